// File: rtl/spread_pkg.sv
// ----------------------------------------------------------------------------
// spread_pkg
//
// Shared definitions for the pipelined spread datapath:
//   - default word / fraction / symbol-count parameters
//   - saturation bounds for the default word width
//   - stage_t: control side-band (valid, symbol tag, sticky saturation flag)
//     that travels beside the arithmetic through every pipeline stage
//   - fp_add_sat: width-generic saturating signed add (words up to FP_MAX_W)
// ----------------------------------------------------------------------------
package spread_pkg;

  localparam int FP_W_DEFAULT        = 64;
  localparam int FRAC_DEFAULT        = 32;
  localparam int NUM_SYMBOLS_DEFAULT = 8;
  localparam int SPREAD_SYM_W        = $clog2(NUM_SYMBOLS_DEFAULT);

  // Widest word fp_add_sat can operate on.
  localparam int FP_MAX_W = 64;

  localparam logic [FP_W_DEFAULT-1:0] SAT_MAX = {1'b0, {(FP_W_DEFAULT-1){1'b1}}};
  localparam logic [FP_W_DEFAULT-1:0] SAT_MIN = {1'b1, {(FP_W_DEFAULT-1){1'b0}}};

  typedef struct packed {
    logic                    valid;
    logic [SPREAD_SYM_W-1:0] sym;
    logic                    sat;
  } stage_t;

  typedef struct packed {
    logic signed [FP_MAX_W-1:0] value;
    logic                       sat;
  } add_res_t;

  // Saturating add of two w-bit signed values presented sign-extended to
  // FP_MAX_W bits. Overflow is detected from the operand and result signs at
  // bit w-1; the caller keeps the low w bits of the returned value.
  function automatic add_res_t fp_add_sat(input logic signed [FP_MAX_W-1:0] a,
                                          input logic signed [FP_MAX_W-1:0] b,
                                          input int                         w);
    logic [FP_MAX_W-1:0] sign_mask;
    logic [FP_MAX_W-1:0] max_v;
    logic [FP_MAX_W-1:0] sum;
    logic                a_neg;
    logic                b_neg;
    logic                s_neg;
    add_res_t            res;
    sign_mask = {{(FP_MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    max_v     = sign_mask - 1'b1;
    sum       = a + b;
    a_neg     = |(a & sign_mask);
    b_neg     = |(b & sign_mask);
    s_neg     = |(sum & sign_mask);
    res.sat   = (a_neg == b_neg) && (s_neg != a_neg);
    if (res.sat) begin
      res.value = a_neg ? ~max_v : max_v;
    end else begin
      res.value = sum;
    end
    return res;
  endfunction

endpackage

// File: rtl/fp_mul_sat.sv
// ----------------------------------------------------------------------------
// fp_mul_sat
//
// One registered pipeline stage: full-width signed multiply, arithmetic shift
// right by FRAC (truncation toward -inf), saturation to a W-bit signed word.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears only the flag)
//   en         : stage enable; when low the outputs hold
//   a [A_W]    : signed multiplicand
//   b [B_W]    : signed multiplier
//   p [W]      : registered saturated product
//   sat        : registered flag, set when p was saturated
// ----------------------------------------------------------------------------
module fp_mul_sat #(
  parameter int W    = 64,
  parameter int FRAC = 32,
  parameter int A_W  = 64,
  parameter int B_W  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  output logic signed [W-1:0] p,
  output logic                sat
);

  localparam int PW = A_W + B_W;

  localparam logic signed [W-1:0] P_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] P_MIN = {1'b1, {(W-1){1'b0}}};

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;
  logic        [PW-W:0] upper;
  logic                 ovf;

  // After the shift the result fits in W bits only if every bit from W-1
  // upward is a copy of the sign; anything else is an overflow.
  always_comb begin
    prod    = PW'(a) * PW'(b);
    shifted = prod >>> FRAC;
    upper   = shifted[PW-1:W-1];
    ovf     = !((&upper) || !(|upper));
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (ovf) begin
        p <= shifted[PW-1] ? P_MIN : P_MAX;
      end else begin
        p <= shifted[W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sat <= 1'b0;
    end else if (en) begin
      sat <= ovf;
    end
  end

endmodule

// File: rtl/spread_pipe.sv
// ----------------------------------------------------------------------------
// spread_pipe
//
// Pipelined spread computation for the quoting path:
//   spread = clamp(sat(sat(sat(risk*vol) * max(horizon - t, 0)) + log))
//
// Pipeline (all stages advance together on en):
//   input reg -> stage 1 (tau, risk*vol) -> stage 2 (*tau) -> stage 3 (+log)
//   -> stage 4 (min/max clamp, output register)
// A sample accepted at edge k is presented at the outputs after edge k+4.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_data_valid/o_in_ready   input handshake
//   i_symbol_id           tag carried unchanged to o_symbol_id
//   i_curr_time, i_horizon    unsigned fixed-point times
//   i_volatility, i_risk_factor, i_logarithm  signed fixed-point operands
//   i_min_spread, i_max_spread  signed clamp bounds
//   o_data_valid/i_out_ready  output handshake
//   o_spread              signed fixed-point result
//   o_saturated           some arithmetic step saturated for this sample
//   o_clamped             result was replaced by a clamp bound
// ----------------------------------------------------------------------------
module spread_pipe
  import spread_pkg::*;
#(
  parameter int FP_WORD_SIZE = FP_W_DEFAULT,
  parameter int FRAC_BITS    = FRAC_DEFAULT,
  parameter int NUM_SYMBOLS  = NUM_SYMBOLS_DEFAULT,
  localparam int SYM_W       = $clog2(NUM_SYMBOLS)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_data_valid,
  output logic                    o_in_ready,
  input  logic [SYM_W-1:0]        i_symbol_id,
  input  logic [FP_WORD_SIZE-1:0] i_curr_time,
  input  logic [FP_WORD_SIZE-1:0] i_horizon,
  input  logic [FP_WORD_SIZE-1:0] i_volatility,
  input  logic [FP_WORD_SIZE-1:0] i_risk_factor,
  input  logic [FP_WORD_SIZE-1:0] i_logarithm,
  input  logic [FP_WORD_SIZE-1:0] i_min_spread,
  input  logic [FP_WORD_SIZE-1:0] i_max_spread,
  output logic                    o_data_valid,
  input  logic                    i_out_ready,
  output logic [FP_WORD_SIZE-1:0] o_spread,
  output logic [SYM_W-1:0]        o_symbol_id,
  output logic                    o_saturated,
  output logic                    o_clamped
);

  localparam int W = FP_WORD_SIZE;

  logic en;

  stage_t in_st;
  stage_t st1;
  stage_t st2;
  stage_t st3;

  logic signed [W-1:0] in_risk;
  logic signed [W-1:0] in_vol;
  logic signed [W-1:0] in_log;
  logic        [W-1:0] in_time;
  logic signed [W-1:0] log1;
  logic signed [W-1:0] log2;
  logic signed [W-1:0] p1;
  logic signed [W-1:0] p2;
  logic signed [W-1:0] sum3;
  logic signed [W-1:0] min_b;
  logic signed [W-1:0] max_b;
  logic signed [W-1:0] clamp_val;
  logic                clamp_hit;
  logic signed [W:0]   tau_c;
  logic signed [W:0]   tau1;
  logic                sat1;
  logic                sat2;
  add_res_t            add_r;

  // The whole pipeline freezes only when a finished result is waiting on a
  // busy consumer. An empty output slot lets bubbles collapse.
  assign en         = !(o_data_valid && !i_out_ready);
  assign o_in_ready = en;

  // Input capture register: control side-band (reset) and operands (no reset).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      in_st <= '0;
    end else if (en) begin
      in_st <= '{valid: i_data_valid, sym: i_symbol_id, sat: 1'b0};
    end
  end

  always_ff @(posedge i_clk) begin
    if (en) begin
      in_risk <= i_risk_factor;
      in_vol  <= i_volatility;
      in_log  <= i_logarithm;
      in_time <= i_curr_time;
    end
  end

  // Remaining time to the horizon, floored at zero and widened by one bit so
  // the stage-2 multiplier sees it as a non-negative signed value.
  always_comb begin
    tau_c = '0;
    if (in_time < i_horizon) begin
      tau_c = {1'b0, i_horizon - in_time};
    end
  end

  // Stage 1: risk * vol, plus tau and log carried alongside.
  fp_mul_sat #(
    .W    (W),
    .FRAC (FRAC_BITS),
    .A_W  (W),
    .B_W  (W)
  ) u_mul_risk_vol (
    .clk   (i_clk),
    .reset (i_reset),
    .en    (en),
    .a     (in_risk),
    .b     (in_vol),
    .p     (p1),
    .sat   (sat1)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      st1 <= '0;
    end else if (en) begin
      st1 <= in_st;
    end
  end

  always_ff @(posedge i_clk) begin
    if (en) begin
      tau1 <= tau_c;
      log1 <= in_log;
    end
  end

  // Stage 2: (risk*vol) * tau.
  fp_mul_sat #(
    .W    (W),
    .FRAC (FRAC_BITS),
    .A_W  (W),
    .B_W  (W + 1)
  ) u_mul_tau (
    .clk   (i_clk),
    .reset (i_reset),
    .en    (en),
    .a     (p1),
    .b     (tau1),
    .p     (p2),
    .sat   (sat2)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      st2 <= '0;
    end else if (en) begin
      st2 <= '{valid: st1.valid, sym: st1.sym, sat: st1.sat | sat1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (en) begin
      log2 <= log1;
    end
  end

  // Stage 3: saturating add of the log term.
  always_comb begin
    add_r = fp_add_sat(FP_MAX_W'(p2), FP_MAX_W'(log2), W);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      st3 <= '0;
    end else if (en) begin
      st3 <= '{valid: st2.valid, sym: st2.sym, sat: st2.sat | sat2 | add_r.sat};
    end
  end

  always_ff @(posedge i_clk) begin
    if (en) begin
      sum3 <= add_r.value[W-1:0];
    end
  end

  // Stage 4 clamp: max is applied first and min second, so an inverted
  // bound pair (min > max) resolves to min.
  always_comb begin
    min_b     = $signed(i_min_spread);
    max_b     = $signed(i_max_spread);
    clamp_val = sum3;
    clamp_hit = 1'b0;
    if (clamp_val > max_b) begin
      clamp_val = max_b;
      clamp_hit = 1'b1;
    end
    if (clamp_val < min_b) begin
      clamp_val = min_b;
      clamp_hit = 1'b1;
    end
  end

  // Output register; flags are qualified by valid so bubbles never raise them.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_data_valid <= 1'b0;
      o_spread     <= '0;
      o_symbol_id  <= '0;
      o_saturated  <= 1'b0;
      o_clamped    <= 1'b0;
    end else if (en) begin
      o_data_valid <= st3.valid;
      o_spread     <= clamp_val;
      o_symbol_id  <= st3.sym;
      o_saturated  <= st3.valid & st3.sat;
      o_clamped    <= st3.valid & clamp_hit;
    end
  end

endmodule

// File: doc/spread_pipe.md
# spread_pipe

Pipelined, multi-symbol successor to the single-stage spread stage of the Avellaneda–Stoikov quoting path. Computes spread = risk·vol·max(horizon − t, 0) + log_term per sample, in signed fixed point. The datapath has explicit per-stage truncation, saturation and min/max clamping. Carries a symbol tag, supports downstream backpressure through a valid/ready handshake, and sits between the volatility/log estimators and the bid/ask quote generator.

## Interface
- FP_WORD_SIZE, 64, signed fixed-point word width W
- FRAC_BITS, 32, fractional bits of every fixed-point operand/result (0 < FRAC_BITS < W)
- NUM_SYMBOLS, 8, symbols in flight; tag width SYM_W = $clog2(NUM_SYMBOLS)
- i_clk  in  1  clock
- i_reset  in  1  reset; synchronous, active-high
- i_data_valid  in  1  input sample valid
- o_in_ready  out  1  pipeline accepts input this cycle
- i_symbol_id  in  SYM_W  symbol tag, passed through unchanged
- i_curr_time  in  W  current time, unsigned Q(W−FRAC).FRAC
- i_horizon  in  W  session end time T, unsigned, quasi-static config
- i_volatility, i_risk_factor, i_logarithm  in  W each  signed fixed point
- i_min_spread, i_max_spread  in  W each  signed clamp bounds, quasi-static config
- o_data_valid  out  1  result valid
- i_out_ready  in  1  downstream accepts result
- o_spread  out  W  signed result
- o_symbol_id  out  SYM_W  tag of o_spread
- o_saturated  out  1  an arithmetic overflow saturated this result
- o_clamped  out  1  result was replaced by a clamp bound

## Operation
- Stage 1: tau = (curr_time ≥ horizon) ? 0 : horizon − curr_time; p1 = sat(risk·vol >>> FRAC_BITS).
- Stage 2: p2 = sat(p1·tau >>> FRAC_BITS). tau is treated as a non-negative signed W+1-bit value.
- Stage 3: s = sat(p2 + log).
- Stage 4: s > max → max; then s < min → min. When min > max, min wins. Register the result to the outputs.
- Multiply: full 2W-bit signed product, then arithmetic shift right by FRAC_BITS (truncation toward −∞).
- Saturation: if the product bits above bit W−1+FRAC_BITS are not a sign extension of bit W−1+FRAC_BITS, output 2^(W−1)−1 or −2^(W−1) according to the product sign. The add saturates the same way.
- o_saturated = OR of the stage 1–3 saturation events for that sample, carried with it. o_clamped = stage-4 substitution.
- Tag, valid and flags travel with the data; output order equals input order.
- No reset of datapath registers is required. Valid bits and flags reset to 0.

## Timing
- Latency: accepted at edge k → o_data_valid at edge k+4, with no stall.
- Throughput: 1 sample/cycle while i_out_ready = 1.
- Stall: en = !(o_data_valid && !i_out_ready). When en = 0, all four stages hold and o_in_ready = 0.
- o_in_ready = en, which is combinational from i_out_ready and the output valid.
- A sample is accepted when i_data_valid && o_in_ready. Bubbles (valid = 0) advance like data and collapse when they reach the output while stalled.
- While o_data_valid && !i_out_ready: o_spread, o_symbol_id and the flags are stable.
- Reset values: o_data_valid = 0, o_spread = 0, o_symbol_id = 0, o_saturated = 0, o_clamped = 0. o_in_ready = 1 in the first cycle after reset.
- Reset mid-stream: every in-flight sample is discarded and none reappears after reset.
- i_horizon and the clamp bounds are sampled at the stage that uses them. They change only while idle.

## Structure
- spread_pkg holds:
  - localparams for W/FRAC defaults
  - the sat-max/sat-min constants
  - a pipeline-stage struct {valid, sym, sat}
  - function fp_add_sat
- Sub-module fp_mul_sat: registered signed multiply + shift + saturate, with an enable and a saturation flag output. It is instantiated for stages 1 and 2.
- Top-level spread_pipe holds tau, the stage-3 add, the stage-4 clamp and the stall logic.

## Test plan
All values use FRAC_BITS = 32, W = 64.
- Basic: risk 0.5 (0x0000_0000_8000_0000), vol 2.0, horizon 3.0, time 2.0, log 0.25, min 0, max 100.0, sym 5 → 4 cycles later o_spread 0x0000_0001_4000_0000, sym 5, both flags 0.
- Expired horizon: same inputs with time 4.0 → o_spread 0x0000_0000_4000_0000 (log only).
- Saturation: risk 2^30, vol 2^30 (integers) → o_spread 0x7FFF_FFFF_FFFF_FFFF, o_saturated 1. Negative risk → 0x8000_0000_0000_0000.
- Clamp: basic case with min 1.5 → o_spread 0x0000_0001_8000_0000, o_clamped 1. With min 2.0 and max 1.0 → o_spread 2.0.
- Backpressure: stream syms 0–7 back-to-back while i_out_ready = 0 for 3 cycles mid-stream → all 8 results delivered in order, no duplicates, outputs stable while stalled.
- Reset: assert i_reset for 1 cycle with 3 samples in flight → o_data_valid stays 0 until new input, then the standard 4-cycle latency.
